// File: rtl/kuz_pkg.sv
// Shared Kuznyechik constants and a reference GF(2^8) multiplier.
// The multiplier works modulo x^8+x^7+x^6+x+1.
package kuz_pkg;

  localparam logic [7:0] GF_POLY = 8'hC3;

  // Coefficients of the L linear layer, in the order the R stage applies them.
  localparam logic [7:0] L_COEFF [16] = '{
    8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
    8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Multiply-by-x in GF(2^8): shift left, fold the overflow bit back with POLY.
module gf_xtime
  import kuz_pkg::*;
#(
  parameter logic [7:0] POLY = GF_POLY
) (
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);

endmodule

// File: rtl/l_convertion_table_148.sv
// Kuznyechik L-layer coefficient unit: output_bytes = input_bytes * COEFF in GF(2^8),
// registered, one result per clock, latency 1.
module l_convertion_table_148
  import kuz_pkg::*;
#(
  parameter logic [7:0] COEFF = L_COEFF[0],
  parameter logic [7:0] POLY  = GF_POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] input_bytes,
  output logic       out_valid,
  output logic [7:0] output_bytes
);

  // taps[k] = xtime^k(input_bytes)
  logic [7:0] taps [8];
  logic [7:0] product;

  assign taps[0] = input_bytes;

  for (genvar k = 0; k < 7; k++) begin : g_chain
    gf_xtime #(.POLY(POLY)) u_xtime (
      .b (taps[k]),
      .y (taps[k+1])
    );
  end

  always_comb begin
    // NOTE: default assigned before the loop so no path leaves product unassigned (no latch).
    product = 8'h00;
    for (int k = 0; k < 8; k++) begin
      product = product ^ (taps[k] & {8{COEFF[k]}});
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      output_bytes <= 8'h00;
    end else begin
      out_valid <= in_valid;
      if (in_valid) output_bytes <= product;
    end
  end

endmodule

// File: tb/tb_l_convertion_table_148.sv
// Self-checking bench for l_convertion_table_148: directed vectors, exhaustive sweep,
// and random linearity pairs against a carry-less-multiply-then-reduce model.
module tb_l_convertion_table_148;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] input_bytes;
  logic       out_valid;
  logic [7:0] output_bytes;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l_convertion_table_148 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .input_bytes  (input_bytes),
    .out_valid    (out_valid),
    .output_bytes (output_bytes)
  );

  // Plain polynomial product by 0x94, then long division by 0x1C3.
  function automatic logic [7:0] ref_mul(input logic [7:0] a);
    int unsigned p;
    p = 0;
    for (int i = 0; i < 8; i++)
      if (a[i]) p = p ^ (32'h94 << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (32'h1C3 << (i - 8));
    return p[7:0];
  endfunction

  // Advance to 1 time unit past the next rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v_exp, input logic [7:0] d_exp);
    total++;
    if (out_valid !== v_exp || output_bytes !== d_exp) begin
      bad++;
      $display("FAIL %s: got valid=%b data=%02h, want valid=%b data=%02h",
               name, out_valid, output_bytes, v_exp, d_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b1; input_bytes = 8'hBC;
    step();
    expect_out("pre_reset_bc", 1'b1, 8'h26);
    #1 rst_n = 1'b0;
    #1 expect_out("async_reset", 1'b0, 8'h00);
    step();
    expect_out("held_in_reset", 1'b0, 8'h00);
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; input_bytes = 8'hBC;
    step();
    expect_out("first_after_reset_bc", 1'b1, 8'h26);
    input_bytes = 8'h15;
    step();
    expect_out("b2b_15", 1'b1, 8'hD5);
  endtask

  task automatic test_hold();
    in_valid = 1'b0; input_bytes = 8'h5A;
    step();
    expect_out("hold_d5", 1'b0, 8'hD5);
    step();
    expect_out("hold_d5_again", 1'b0, 8'hD5);
  endtask

  task automatic test_directed();
    logic [7:0] ins  [4] = '{8'h01, 8'h00, 8'h02, 8'h80};
    logic [7:0] outs [4] = '{8'h94, 8'h00, 8'hEB, 8'hE5};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      input_bytes = ins[i];
      step();
      expect_out($sformatf("vec_%02h", ins[i]), 1'b1, outs[i]);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_exhaustive();
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      input_bytes = i[7:0];
      step();
      expect_out($sformatf("exh_%02h", i), 1'b1, ref_mul(i[7:0]));
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_linearity();
    logic [7:0] a, b, fa, fb, fab;
    in_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      input_bytes = a;      step(); fa  = output_bytes;
      input_bytes = b;      step(); fb  = output_bytes;
      input_bytes = a ^ b;  step(); fab = output_bytes;
      total++;
      if (fab !== (fa ^ fb) || fa !== ref_mul(a)) begin
        bad++;
        $display("FAIL linear a=%02h b=%02h: f(a^b)=%02h f(a)^f(b)=%02h f(a)=%02h want f(a)=%02h",
                 a, b, fab, fa ^ fb, fa, ref_mul(a));
      end
    end
    in_valid = 1'b0;
    step();
    expect_out("idle_after_linear", 1'b0, fab);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; input_bytes = 8'h00;
    #1 expect_out("power_on_reset", 1'b0, 8'h00);
    step();
    test_reset();
    test_back_to_back();
    test_hold();
    test_directed();
    test_exhaustive();
    test_linearity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
